// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_pkg
//  Description : Definitions shared by sensor_conditioner and
//                trafficlightcontroller. Holds the one-hot light encodings,
//                the loop-detector FSM state encoding and a small light decode
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

  // One-hot light encodings, identical to the traffic light controller's.
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  // Loop-detector debounce FSM.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    QUAL    = 2'b01,
    PRESENT = 2'b10,
    RELEASE = 2'b11
  } sc_state_t;

  function automatic logic is_green(input logic [2:0] light);
    return (light == GREEN);
  endfunction

endpackage : tlc_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : Multi-flop synchronizer for a single asynchronous level.
//                All stages clear asynchronously on i_rst_n low. Only the
//                last stage is meant to be used by downstream logic.
//  Ports       : clk     - sampling clock
//                i_rst_n - asynchronous active-low clear
//                i_d     - asynchronous input level
//                o_q     - synchronized level (last stage)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_conditioner
//  Description : Conditions the farm-road loop detector for the traffic light
//                controller: synchronizes the raw level, debounces it with a
//                four-state FSM, latches a vehicle request, counts confirmed
//                arrivals (saturating) and flags a loop that stays occupied
//                for too long.
//  Ports       : clk           - system clock, rising edge
//                reset         - asynchronous active-low reset
//                raw_sensor    - unsynchronized loop detector level
//                light_FM      - farm-road light from the controller
//                sensor        - registered vehicle request
//                vehicle_count - saturating confirmed-arrival count
//                stuck_fault   - registered loop-stuck indication
//  Revision    : 1.0 - initial release
// ============================================================================
module sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_LIMIT     = 1000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_sensor,
  input  logic [2:0]       light_FM,
  output logic             sensor,
  output logic [CNT_W-1:0] vehicle_count,
  output logic             stuck_fault
);

  // The debounce counter only ever holds 1 .. DEBOUNCE_CYCLES-1.
  localparam int DEB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int STK_W = $clog2(STUCK_LIMIT + 1);

  localparam logic [DEB_W-1:0] c_deb_zero   = '0;
  localparam logic [DEB_W-1:0] c_deb_one    = DEB_W'(1);
  localparam logic [DEB_W-1:0] c_deb_last   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STK_W-1:0] c_stuck_zero = '0;
  localparam logic [STK_W-1:0] c_stuck_lim  = STK_W'(STUCK_LIMIT);
  localparam logic [CNT_W-1:0] c_count_max  = '1;

  // --------------------------------------------------------------------------
  // Reset: asserts immediately, releases two clk edges after the pin rises so
  // that every downstream flop leaves reset on the same clean edge.
  // --------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // --------------------------------------------------------------------------
  // Input synchronizer
  // --------------------------------------------------------------------------
  logic w_sync;

  sync_ff #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_ff (
    .clk     (clk),
    .i_rst_n (w_rst_n),
    .i_d     (raw_sensor),
    .o_q     (w_sync)
  );

  // --------------------------------------------------------------------------
  // Debounce FSM with stuck supervision
  // --------------------------------------------------------------------------
  sc_state_t        r_state;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [STK_W-1:0] r_stuck_cnt;
  logic             r_stuck_fault;
  logic             r_arrival;      // one-cycle pulse after a confirmed arrival

  logic w_deb_done;
  logic w_stuck_hit;

  // ">=" lets DEBOUNCE_CYCLES=1 confirm on the first qualifying sample, since
  // the counter is already 1 on entry to QUAL/RELEASE.
  assign w_deb_done  = (r_deb_cnt >= c_deb_last);

  // This PRESENT cycle brings the stuck counter up to the limit.
  assign w_stuck_hit = (r_state == PRESENT) && w_sync &&
                       (r_stuck_cnt == c_stuck_lim - STK_W'(1));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= IDLE;
      r_deb_cnt     <= c_deb_zero;
      r_stuck_cnt   <= c_stuck_zero;
      r_stuck_fault <= 1'b0;
      r_arrival     <= 1'b0;
    end else begin
      r_arrival <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_sync) begin
            r_state   <= QUAL;
            r_deb_cnt <= c_deb_one;
          end
        end

        QUAL: begin
          if (!w_sync) begin
            r_state   <= IDLE;
            r_deb_cnt <= c_deb_zero;
          end else if (w_deb_done) begin
            r_state   <= PRESENT;
            r_deb_cnt <= c_deb_zero;
            r_arrival <= 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end

        PRESENT: begin
          if (!w_sync) begin
            r_state     <= RELEASE;
            r_deb_cnt   <= c_deb_one;
            r_stuck_cnt <= c_stuck_zero;
          end else begin
            if (r_stuck_cnt != c_stuck_lim) begin
              r_stuck_cnt <= r_stuck_cnt + STK_W'(1);
            end
            if (w_stuck_hit) begin
              r_stuck_fault <= 1'b1;
            end
          end
        end

        RELEASE: begin
          if (w_sync) begin
            r_state   <= PRESENT;
            r_deb_cnt <= c_deb_zero;
          end else if (w_deb_done) begin
            // Only a genuine return to IDLE clears a stuck fault.
            r_state       <= IDLE;
            r_deb_cnt     <= c_deb_zero;
            r_stuck_cnt   <= c_stuck_zero;
            r_stuck_fault <= 1'b0;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end

        default: begin
          r_state   <= IDLE;
          r_deb_cnt <= c_deb_zero;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Request latch and arrival counter, both updated from the registered
  // arrival pulse so the request rises SYNC_STAGES+DEBOUNCE_CYCLES edges
  // after raw_sensor is first sampled high.
  // --------------------------------------------------------------------------
  logic             r_sensor;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sensor <= 1'b0;
    end else if (r_stuck_fault || w_stuck_hit) begin
      // A stuck loop must not keep requesting green.
      r_sensor <= 1'b0;
    end else if (r_arrival) begin
      r_sensor <= 1'b1;
    end else if (is_green(light_FM) && (r_state != PRESENT)) begin
      // Served: the farm road got green and the vehicle has left the loop.
      r_sensor <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_count <= '0;
    end else if (r_arrival && (r_count != c_count_max)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign sensor        = r_sensor;
  assign vehicle_count = r_count;
  assign stuck_fault   = r_stuck_fault;

endmodule : sensor_conditioner
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sensor_conditioner
//  Description : Self-checking bench for sensor_conditioner. One instance with
//                default parameters, a second with CNT_W=2 for saturation.
//                Expected arrival counts are queued when stimulus is driven
//                and popped when the request output rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_conditioner;
  import tlc_pkg::*;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       raw_sensor = 1'b0;
  logic       raw2       = 1'b0;
  logic [2:0] light_FM   = RED;

  logic       sensor, stuck_fault;
  logic [7:0] vehicle_count;
  logic       sensor2, stuck2;
  logic [1:0] count2;

  int tests_run = 0;
  int failures  = 0;
  int m_cnt     = 0;
  int m_cnt2    = 0;
  int exp_q[$];
  int exp_q2[$];
  int e1, e2;
  logic prev_s  = 1'b0;
  logic prev_s2 = 1'b0;

  always #5 clk = ~clk;

  sensor_conditioner dut (
    .clk           (clk),
    .reset         (reset),
    .raw_sensor    (raw_sensor),
    .light_FM      (light_FM),
    .sensor        (sensor),
    .vehicle_count (vehicle_count),
    .stuck_fault   (stuck_fault)
  );

  sensor_conditioner #(.CNT_W(2)) dut_c2 (
    .clk           (clk),
    .reset         (reset),
    .raw_sensor    (raw2),
    .light_FM      (light_FM),
    .sensor        (sensor2),
    .vehicle_count (count2),
    .stuck_fault   (stuck2)
  );

  // Scoreboard: each rising request must match the next queued count.
  always @(negedge clk) begin
    if (sensor === 1'b1 && prev_s === 1'b0) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_arrival: unexpected request rise, count=%0d", vehicle_count);
      end else begin
        e1 = exp_q.pop_front();
        if (vehicle_count !== 8'(e1)) begin
          failures++;
          $display("FAIL sb_arrival: count=%0d required %0d", vehicle_count, e1);
        end
      end
    end
    if (sensor2 === 1'b1 && prev_s2 === 1'b0) begin
      tests_run++;
      if (exp_q2.size() == 0) begin
        failures++;
        $display("FAIL sb_arrival_c2: unexpected request rise, count=%0d", count2);
      end else begin
        e2 = exp_q2.pop_front();
        if (count2 !== 2'(e2)) begin
          failures++;
          $display("FAIL sb_arrival_c2: count=%0d required %0d", count2, e2);
        end
      end
    end
    prev_s  = sensor;
    prev_s2 = sensor2;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #3 reset = 1'b0;
    #1;
    tests_run++;
    if (sensor !== 1'b0 || vehicle_count !== 8'd0 || stuck_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: sensor=%b count=%0d fault=%b required 0 0 0",
               sensor, vehicle_count, stuck_fault);
    end
    tick(3);
    reset = 1'b1;
    tick(4);
    tests_run++;
    if (sensor !== 1'b0 || vehicle_count !== 8'd0 || stuck_fault !== 1'b0 ||
        sensor2 !== 1'b0 || count2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_release: sensor=%b count=%0d fault=%b c2=%0d required all 0",
               sensor, vehicle_count, stuck_fault, count2);
    end
  endtask

  task automatic test_arrival;
    raw_sensor = 1'b1;
    m_cnt++;
    exp_q.push_back(m_cnt);
    for (int k = 0; k <= 6; k++) begin
      tick(1);
      tests_run++;
      if (sensor !== (k >= 6)) begin
        failures++;
        $display("FAIL arrival_latency: edge %0d sensor=%b required %b", k, sensor, (k >= 6));
      end
    end
    tick(13);
    tests_run++;
    if (vehicle_count !== 8'(m_cnt) || stuck_fault !== 1'b0) begin
      failures++;
      $display("FAIL arrival_count: count=%0d fault=%b required %0d 0",
               vehicle_count, stuck_fault, m_cnt);
    end
  endtask

  task automatic test_green_clear;
    light_FM = GREEN;
    tick(2);
    tests_run++;
    if (sensor !== 1'b1) begin
      failures++;
      $display("FAIL green_hold_present: sensor=%b required 1", sensor);
    end
    light_FM   = RED;
    raw_sensor = 1'b0;
    tick(10);
    tests_run++;
    if (sensor !== 1'b1) begin
      failures++;
      $display("FAIL request_pending: sensor=%b required 1", sensor);
    end
    light_FM = GREEN;
    tick(1);
    light_FM = RED;
    tests_run++;
    if (sensor !== 1'b0) begin
      failures++;
      $display("FAIL green_clear: sensor=%b required 0", sensor);
    end
  endtask

  task automatic test_glitch;
    raw_sensor = 1'b1; tick(1); raw_sensor = 1'b0; tick(10);
    raw_sensor = 1'b1; tick(3); raw_sensor = 1'b0; tick(10);
    tests_run++;
    if (sensor !== 1'b0 || vehicle_count !== 8'(m_cnt)) begin
      failures++;
      $display("FAIL glitch_reject: sensor=%b count=%0d required 0 %0d",
               sensor, vehicle_count, m_cnt);
    end
    // Four synchronized samples is the shortest pulse that confirms.
    raw_sensor = 1'b1;
    m_cnt++;
    exp_q.push_back(m_cnt);
    tick(4);
    raw_sensor = 1'b0;
    tick(12);
    tests_run++;
    if (sensor !== 1'b1 || vehicle_count !== 8'(m_cnt)) begin
      failures++;
      $display("FAIL min_pulse: sensor=%b count=%0d required 1 %0d",
               sensor, vehicle_count, m_cnt);
    end
    light_FM = GREEN; tick(1); light_FM = RED;
  endtask

  task automatic test_stuck;
    raw_sensor = 1'b1;
    m_cnt++;
    exp_q.push_back(m_cnt);
    tick(1005);
    tests_run++;
    if (stuck_fault !== 1'b0 || sensor !== 1'b1) begin
      failures++;
      $display("FAIL stuck_before_limit: fault=%b sensor=%b required 0 1", stuck_fault, sensor);
    end
    tick(1);
    tests_run++;
    if (stuck_fault !== 1'b1 || sensor !== 1'b0) begin
      failures++;
      $display("FAIL stuck_at_limit: fault=%b sensor=%b required 1 0", stuck_fault, sensor);
    end
    tick(30);
    tests_run++;
    if (stuck_fault !== 1'b1 || sensor !== 1'b0) begin
      failures++;
      $display("FAIL stuck_hold: fault=%b sensor=%b required 1 0", stuck_fault, sensor);
    end
    raw_sensor = 1'b0;
    tick(3);
    tests_run++;
    if (stuck_fault !== 1'b1) begin
      failures++;
      $display("FAIL stuck_release_keep: fault=%b required 1", stuck_fault);
    end
    tick(3);
    tests_run++;
    if (stuck_fault !== 1'b0 || sensor !== 1'b0 || vehicle_count !== 8'(m_cnt)) begin
      failures++;
      $display("FAIL stuck_clear: fault=%b sensor=%b count=%0d required 0 0 %0d",
               stuck_fault, sensor, vehicle_count, m_cnt);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 5; i++) begin
      raw2 = 1'b1;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      exp_q2.push_back(m_cnt2);
      tick(10);
      tests_run++;
      if (count2 !== 2'(m_cnt2) || sensor2 !== 1'b1 || stuck2 !== 1'b0) begin
        failures++;
        $display("FAIL saturate_%0d: count=%0d sensor=%b fault=%b required %0d 1 0",
                 i, count2, sensor2, stuck2, m_cnt2);
      end
      raw2 = 1'b0;
      tick(10);
      light_FM = GREEN; tick(1); light_FM = RED;
    end
  endtask

  task automatic test_async_reset;
    // Reset in the middle of qualification.
    raw_sensor = 1'b1;
    tick(4);
    #2 reset = 1'b0;
    m_cnt = 0; m_cnt2 = 0;
    #1;
    tests_run++;
    if (sensor !== 1'b0 || vehicle_count !== 8'd0 || stuck_fault !== 1'b0 || count2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_qual: sensor=%b count=%0d fault=%b c2=%0d required 0",
               sensor, vehicle_count, stuck_fault, count2);
    end
    raw_sensor = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(20);
    tests_run++;
    if (sensor !== 1'b0 || vehicle_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_no_spurious: sensor=%b count=%0d required 0 0", sensor, vehicle_count);
    end
    // Reset with a request pending.
    raw_sensor = 1'b1;
    m_cnt++;
    exp_q.push_back(m_cnt);
    tick(8);
    tests_run++;
    if (sensor !== 1'b1) begin
      failures++;
      $display("FAIL pending_before_reset: sensor=%b required 1", sensor);
    end
    #2 reset = 1'b0;
    m_cnt = 0;
    #1;
    tests_run++;
    if (sensor !== 1'b0 || vehicle_count !== 8'd0 || stuck_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_pending: sensor=%b count=%0d fault=%b required 0 0 0",
               sensor, vehicle_count, stuck_fault);
    end
    raw_sensor = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(20);
    tests_run++;
    if (sensor !== 1'b0 || vehicle_count !== 8'd0 || count2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_pending_after: sensor=%b count=%0d c2=%0d required 0 0 0",
               sensor, vehicle_count, count2);
    end
  endtask

  initial begin
    test_reset();
    test_arrival();
    test_green_clear();
    test_glitch();
    test_stuck();
    test_saturation();
    test_async_reset();
    tests_run++;
    if (exp_q.size() != 0 || exp_q2.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d/%0d required 0/0", exp_q.size(), exp_q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule : tb_sensor_conditioner
`default_nettype wire

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (min 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples needed to accept a level change (min 1).
REQ-003 SHALL have parameter STUCK_LIMIT, default 1000, consecutive PRESENT cycles after which the loop is declared stuck.
REQ-004 SHALL have parameter CNT_W, default 8, width of vehicle_count.
REQ-005 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port raw_sensor, input, 1, unsynchronized farm-road loop detector level.
REQ-008 SHALL have port light_FM, input, 3, farm-road light fed back from the traffic light controller.
REQ-009 SHALL have port sensor, output, 1, registered vehicle request driving the traffic light controller sensor input.
REQ-010 SHALL have port vehicle_count, output, CNT_W, saturating count of confirmed arrivals.
REQ-011 SHALL have port stuck_fault, output, 1, registered loop-stuck indication.

Function
REQ-012 SHALL pass raw_sensor through a SYNC_STAGES flop chain; only the last stage (sync) is used downstream.
REQ-013 SHALL implement FSM states IDLE, QUAL, PRESENT, RELEASE with a debounce counter.
REQ-014 IDLE: sync=1 -> QUAL, counter=1; else stay.
REQ-015 QUAL: sync=0 -> IDLE, counter cleared; sync=1 and counter=DEBOUNCE_CYCLES-1 -> PRESENT (confirmed arrival); else counter+1.
REQ-016 PRESENT: sync=0 -> RELEASE, counter=1; else stay, incrementing the stuck counter.
REQ-017 RELEASE: sync=1 -> PRESENT, counter cleared; sync=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-018 With DEBOUNCE_CYCLES=1, the QUAL->PRESENT and RELEASE->IDLE transitions SHALL occur on the first qualifying sample.
REQ-019 A confirmed arrival SHALL set the request latch; sensor rises on the edge SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge sampling raw_sensor=1 (6 edges at defaults).
REQ-020 The request latch SHALL clear on the edge after a cycle with light_FM==GREEN and FSM not in PRESENT.
REQ-021 When set and clear conditions coincide, set SHALL win.
REQ-022 vehicle_count SHALL increment by 1 on each confirmed arrival and saturate at 2^CNT_W-1 with no wrap.
REQ-023 stuck_fault SHALL assert when the stuck counter reaches STUCK_LIMIT; while asserted the request latch is forced to 0 and sets are ignored.
REQ-024 stuck_fault SHALL clear, and the stuck counter SHALL zero, on entry to IDLE; entry to RELEASE SHALL zero the stuck counter only.
REQ-025 The stuck counter SHALL saturate at STUCK_LIMIT.
REQ-026 Glitches on raw_sensor shorter than DEBOUNCE_CYCLES synchronized cycles SHALL change neither sensor nor vehicle_count.

Reset
REQ-027 reset low SHALL immediately clear the synchronizer flops, FSM (IDLE), all counters, sensor=0, vehicle_count=0, and stuck_fault=0, regardless of clk.
REQ-028 Reset asserted mid-qualification or with a request pending SHALL discard that event with no count increment; reset release SHALL be synchronized to clk internally.

Structure
REQ-029 Shared package tlc_pkg SHALL hold the light encodings RED=3'b100, YELLOW=3'b010, GREEN=3'b001 and the FSM state encoding, and SHALL be shared with trafficlightcontroller.
REQ-030 The synchronizer SHALL be a separate sub-module named sync_ff, parameterized by SYNC_STAGES; all other logic stays in sensor_conditioner.

Verification
REQ-031 With defaults, raw_sensor high for 20 cycles -> sensor rises 6 edges after first sample, vehicle_count=1, stuck_fault=0.
REQ-032 With defaults, raw_sensor 1-cycle and 3-cycle pulses -> sensor stays 0, vehicle_count stays 0.
REQ-033 Request pending, raw_sensor low, light_FM=3'b001 for 1 cycle -> sensor=0 on the next edge; light_FM=3'b001 while PRESENT -> sensor holds 1.
REQ-034 With defaults, raw_sensor held high 1000+ cycles -> stuck_fault=1 and sensor=0 after 1000 PRESENT cycles; raw_sensor low for 4 cycles -> stuck_fault=0.
REQ-035 With CNT_W=2, 5 clean arrivals -> vehicle_count reads 1, 2, 3, 3, 3.
REQ-036 reset pulled low asynchronously mid-QUAL and again with sensor=1 -> all outputs 0 immediately; after reset release, no spurious arrival is counted.
